hazard_scoreboard_unit: RTL

Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W). It generates per-stage stall/flush and D/E forwarding selects, as the existing combinational hazard logic does. It also adds:
- a registered scoreboard for one outstanding multi-cycle (mul/div) result;
- explicit register-0 suppression;
- a defined default for every output;
- a saturating stall-cycle performance counter.

---
 rtl/hazard_scoreboard_unit_pkg.sv | 29 ++
 rtl/hazard_scoreboard_unit_md_scoreboard.sv | 67 ++++++
 rtl/hazard_scoreboard_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: forwarding select
// encodings, stage-control struct layout and the hard-wired zero register id.
package hazard_scoreboard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int unsigned REG_ZERO = 0;

    // Stall vector index: F, D, E, M, W.
    localparam int unsigned ST_F = 0;
    localparam int unsigned ST_D = 1;
    localparam int unsigned ST_E = 2;
    localparam int unsigned ST_M = 3;
    localparam int unsigned ST_W = 4;

    // Flush vector index: D, E, M, W (F is never bubbled, only redirected).
    localparam int unsigned FL_D = 0;
    localparam int unsigned FL_E = 1;
    localparam int unsigned FL_M = 2;
    localparam int unsigned FL_W = 3;

    typedef struct packed {
        logic [4:0] stall;
        logic [3:0] flush;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_scoreboard_unit_md_scoreboard.sv
// Single-entry scoreboard tracking one outstanding mul/div result and the
// D-stage interlock it imposes until the result becomes writable.
module md_scoreboard
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 7,
    parameter int unsigned LAT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              issue_i,
    input  logic [LAT_W-1:0]  lat_i,
    input  logic [REG_AW-1:0] wreg_i,
    input  logic [REG_AW-1:0] rs_d_i,
    input  logic [REG_AW-1:0] rt_d_i,
    input  logic              md_op_d_i,
    output logic              busy_o,
    output logic              hazard_o
);

    logic              pend_v_q, pend_v_d;
    logic [REG_AW-1:0] pend_reg_q, pend_reg_d;
    logic [LAT_W-1:0]  pend_cnt_q, pend_cnt_d;
    logic              rs_hit, rt_hit;

    // A fresh issue outranks both the running countdown and its expiry.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_reg_d = pend_reg_q;
        pend_cnt_d = pend_cnt_q;
        if (clear_i) begin
            pend_v_d   = 1'b0;
            pend_reg_d = '0;
            pend_cnt_d = '0;
        end else if (issue_i && (lat_i != '0)) begin
            pend_v_d   = 1'b1;
            pend_reg_d = wreg_i;
            pend_cnt_d = lat_i;
        end else if (pend_v_q) begin
            if (pend_cnt_q == LAT_W'(1)) begin
                pend_v_d   = 1'b0;
                pend_cnt_d = '0;
            end else begin
                pend_cnt_d = pend_cnt_q - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q   <= 1'b0;
            pend_reg_q <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_reg_q <= pend_reg_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign rs_hit   = (rs_d_i == pend_reg_q) && (pend_reg_q != REG_AW'(REG_ZERO));
    assign rt_hit   = (rt_d_i == pend_reg_q) && (pend_reg_q != REG_AW'(REG_ZERO));
    assign hazard_o = pend_v_q && (rs_hit || rt_hit || md_op_d_i);
    assign busy_o   = pend_v_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, stall/flush
// priority, mul/div scoreboard interlock and a saturating stall counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 7,
    parameter int unsigned LAT_W  = 6,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_clear_i,
    input  logic              exc_stall_i,
    input  logic              is_branch_d_i,
    input  logic              branch_taken_d_i,
    input  logic              md_op_d_i,
    input  logic [REG_AW-1:0] rs_d_i,
    input  logic [REG_AW-1:0] rt_d_i,
    input  logic [REG_AW-1:0] rs_e_i,
    input  logic [REG_AW-1:0] rt_e_i,
    input  logic [REG_AW-1:0] wreg_e_i,
    input  logic [REG_AW-1:0] wreg_m_i,
    input  logic [REG_AW-1:0] wreg_w_i,
    input  logic              regwrite_e_i,
    input  logic              regwrite_m_i,
    input  logic              regwrite_w_i,
    input  logic              memtoreg_e_i,
    input  logic              memtoreg_m_i,
    input  logic              md_issue_e_i,
    input  logic [LAT_W-1:0]  md_lat_e_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              stall_e_o,
    output logic              stall_m_o,
    output logic              stall_w_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              flush_m_o,
    output logic              flush_w_o,
    output logic [1:0]        fwd_a_d_o,
    output logic [1:0]        fwd_b_d_o,
    output logic [1:0]        fwd_a_e_o,
    output logic [1:0]        fwd_b_e_o,
    output logic              md_busy_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    stage_ctrl_t      ctrl;
    logic             lu_haz, br_haz, md_haz;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    // Register 0 is hard-wired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] dst);
        return (src == dst) && (dst != REG_AW'(REG_ZERO));
    endfunction

    // A load in M has no data yet, so only ALU results forward from M.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (regwrite_m_i && !memtoreg_m_i && reg_match(src, wreg_m_i))
            return FWD_M;
        else if (regwrite_w_i && reg_match(src, wreg_w_i))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

    assign fwd_a_e_o = fwd_sel(rs_e_i);
    assign fwd_b_e_o = fwd_sel(rt_e_i);
    assign fwd_a_d_o = fwd_sel(rs_d_i);
    assign fwd_b_d_o = fwd_sel(rt_d_i);

    assign lu_haz = regwrite_e_i && memtoreg_e_i &&
                    (reg_match(rs_d_i, wreg_e_i) || reg_match(rt_d_i, wreg_e_i));

    assign br_haz = is_branch_d_i &&
                    ((regwrite_e_i &&
                      (reg_match(rs_d_i, wreg_e_i) || reg_match(rt_d_i, wreg_e_i))) ||
                     (memtoreg_m_i &&
                      (reg_match(rs_d_i, wreg_m_i) || reg_match(rt_d_i, wreg_m_i))));

    md_scoreboard #(
        .REG_AW (REG_AW),
        .LAT_W  (LAT_W)
    ) u_md_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (exc_clear_i),
        .issue_i   (md_issue_e_i),
        .lat_i     (md_lat_e_i),
        .wreg_i    (wreg_e_i),
        .rs_d_i    (rs_d_i),
        .rt_d_i    (rt_d_i),
        .md_op_d_i (md_op_d_i),
        .busy_o    (md_busy_o),
        .hazard_o  (md_haz)
    );

    always_comb begin
        ctrl = '0;
        if (exc_clear_i) begin
            ctrl.flush = '1;
        end else if (exc_stall_i) begin
            ctrl.stall = '1;
        end else if (md_haz || lu_haz || br_haz) begin
            ctrl.stall[ST_F] = 1'b1;
            ctrl.stall[ST_D] = 1'b1;
            ctrl.flush[FL_E] = 1'b1;
        end else if (branch_taken_d_i) begin
            ctrl.flush[FL_D] = 1'b1;
        end
    end

    assign stall_f_o = ctrl.stall[ST_F];
    assign stall_d_o = ctrl.stall[ST_D];
    assign stall_e_o = ctrl.stall[ST_E];
    assign stall_m_o = ctrl.stall[ST_M];
    assign stall_w_o = ctrl.stall[ST_W];
    assign flush_d_o = ctrl.flush[FL_D];
    assign flush_e_o = ctrl.flush[FL_E];
    assign flush_m_o = ctrl.flush[FL_M];
    assign flush_w_o = ctrl.flush[FL_W];

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_f_o && (stall_cycles_q != '1))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles_o = stall_cycles_q;

endmodule
